// File: rtl/axi_slave_port_arbiter_pkg.sv
// Shared crossbar package for the AXI4 slave-port arbiters.
// Holds the arbiter state enum, crossbar size defaults and a one-hot to
// binary index helper used by the round-robin picker.
// Optional feature macro used by the arbiter: AXI_ARB_TIMEOUT_EN.
package axi_slave_port_arbiter_pkg;

  // Crossbar dimensions
  localparam int SLAVE_NUM      = 4;
  localparam int MASTER_NUM_DEF = 4;

  // Widest one-hot vector the index helper accepts, and its index width
  localparam int ONEHOT_MAX = 32;
  localparam int IDX_MAX_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // OR together the positions of the set bits; for a true one-hot input
  // this is simply the position of the single set bit
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [ONEHOT_MAX-1:0] oh);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ONEHOT_MAX; i++) begin
      if (oh[i]) idx = idx | IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/axi_slave_port_arbiter_rr_priority_pick.sv
// Combinational round-robin picker.
// Ports:
//   req      in  MASTER_NUM  request vector
//   rr_ptr   in  IDX_W       highest-priority position for this pick
//   pick_oh  out MASTER_NUM  one-hot winner (all zero when req is zero)
//   pick_idx out IDX_W       binary index of the winner
module rr_priority_pick
  import axi_slave_port_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = MASTER_NUM_DEF,
  parameter int IDX_W      = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [MASTER_NUM-1:0] pick_oh,
  output logic [IDX_W-1:0]      pick_idx
);

  localparam int DW = 2 * MASTER_NUM;

  logic [DW-1:0] dbl;
  logic [DW-1:0] masked;
  logic [DW-1:0] first;

  // The request vector is duplicated so that a plain lowest-set-bit search
  // starting at rr_ptr naturally wraps around: bits below rr_ptr in the lower
  // copy are masked off, but the upper copy still offers them after the
  // higher-numbered masters. Folding the two halves gives the one-hot winner.
  always_comb begin
    dbl      = {req, req};
    masked   = dbl & ~((DW'(1) << rr_ptr) - DW'(1));
    first    = masked & (~masked + DW'(1));
    pick_oh  = first[MASTER_NUM-1:0] | first[DW-1:MASTER_NUM];
    pick_idx = IDX_W'(onehot_to_idx(ONEHOT_MAX'(pick_oh)));
  end

endmodule

// File: rtl/axi_slave_port_arbiter.sv
// Per-slave-port round-robin arbiter for one AXI4 crossbar direction
// (one instance on each slave's AR path and one on each AW path).
// A grant is held from selection through the address handshake until the
// final beat / write response so data and response routing stays stable.
// Optional feature macro: AXI_ARB_TIMEOUT_EN adds a watchdog that force-
// releases a grant held for TIMEOUT_CYCLES clocks in ADDR or DATA.
// Ports:
//   clk          in  crossbar clock
//   rst          in  synchronous active-high reset
//   req          in  per-master request (decoded slave hit & VALID)
//   addr_hs      in  address handshake of the granted transfer
//   done         in  completion (last R beat or B handshake)
//   grant        out one-hot grant
//   grant_idx    out binary index of granted master
//   grant_valid  out grant active
//   busy         out address accepted, completion outstanding
//   timeout_err  out one-cycle watchdog pulse (0 without the macro)
module axi_slave_port_arbiter
  import axi_slave_port_arbiter_pkg::*;
#(
  parameter int MASTER_NUM     = MASTER_NUM_DEF,
  parameter int IDX_W          = $clog2(MASTER_NUM),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] req,
  input  logic                  addr_hs,
  input  logic                  done,
  output logic [MASTER_NUM-1:0] grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_valid,
  output logic                  busy,
  output logic                  timeout_err
);

  arb_state_e state, state_n;
  logic [MASTER_NUM-1:0] grant_n;
  logic [IDX_W-1:0]      idx_n;
  logic                  gv_n;
  logic                  busy_n;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_n;
  logic                  release_c;
  logic [MASTER_NUM-1:0] pick_oh;
  logic [IDX_W-1:0]      pick_idx;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             terr_n;
`endif

  rr_priority_pick #(
    .MASTER_NUM (MASTER_NUM),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx)
  );

  // Next-state and next-output logic. The grant is only ever loaded in IDLE,
  // so it is frozen for the whole ADDR/DATA residency. A release (done, or a
  // watchdog expiry) advances the round-robin pointer past the served master;
  // a request withdrawn in ADDR drops the grant without advancing, since
  // that master was never actually served.
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    idx_n     = grant_idx;
    gv_n      = grant_valid;
    busy_n    = busy;
    rr_ptr_n  = rr_ptr;
    release_c = 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
    cnt_n  = cnt;
    terr_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = ADDR;
          grant_n = pick_oh;
          idx_n   = pick_idx;
          gv_n    = 1'b1;
`ifdef AXI_ARB_TIMEOUT_EN
          cnt_n = '0;
`endif
        end
      end
      ADDR: begin
        if (addr_hs) begin
          state_n = DATA;
          busy_n  = 1'b1;
`ifdef AXI_ARB_TIMEOUT_EN
          cnt_n = '0;
`endif
        end else if (!req[grant_idx]) begin
          state_n = IDLE;
          grant_n = '0;
          idx_n   = '0;
          gv_n    = 1'b0;
        end
`ifdef AXI_ARB_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          terr_n    = 1'b1;
          release_c = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`endif
      end
      DATA: begin
        if (done) begin
          release_c = 1'b1;
        end
`ifdef AXI_ARB_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          terr_n    = 1'b1;
          release_c = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    if (release_c) begin
      state_n  = IDLE;
      grant_n  = '0;
      idx_n    = '0;
      gv_n     = 1'b0;
      busy_n   = 1'b0;
      rr_ptr_n = (grant_idx == IDX_W'(MASTER_NUM - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // State and registered outputs; reset discards any outstanding transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
      rr_ptr      <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_idx   <= idx_n;
      grant_valid <= gv_n;
      busy        <= busy_n;
      rr_ptr      <= rr_ptr_n;
    end
  end

`ifdef AXI_ARB_TIMEOUT_EN
  // Watchdog counter and its one-cycle error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      timeout_err <= terr_n;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule
